// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encoding and time-to-cycle conversion for button_conditioner
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } btn_state_t;

    // Converts a duration in microseconds to whole clock cycles, never less than one.
    function automatic int us_to_cycles(input int us, input int clk_per);
        longint c;
        c = (longint'(us) * 64'sd1000) / longint'(clk_per);
        return (c < 1) ? 1 : int'(c);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-flop synchroniser for one asynchronous input bit
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounces one raw push-button into press/release/repeat pulses
module button_conditioner
    import button_pkg::*;
#(
    parameter int CLK_PER       = 10,
    parameter int DEBOUNCE_US   = 5000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DLY_US = 500000,
    parameter int REPEAT_PER_US = 100000
) (
    input  logic clk,
    input  logic CPU_RESETN,
    input  logic BTNC,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat,
    output logic btn_down
);

    localparam int DB_CNT  = us_to_cycles(DEBOUNCE_US, CLK_PER);
    localparam int RD_CNT  = us_to_cycles(REPEAT_DLY_US, CLK_PER);
    localparam int RP_CNT  = us_to_cycles(REPEAT_PER_US, CLK_PER);
    localparam int REP_MAX = (RD_CNT > RP_CNT) ? RD_CNT : RP_CNT;
    localparam int DB_W    = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CNT - 1);
    localparam logic [REP_W-1:0] RD_LAST = REP_W'(RD_CNT - 1);
    localparam logic [REP_W-1:0] RP_LAST = REP_W'(RP_CNT - 1);

    logic s;

    bit_sync #(.STAGES(2)) u_sync (
        .clk   (clk),
        .rst_n (CPU_RESETN),
        .d     (BTNC),
        .q     (s)
    );

    btn_state_t       state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             first_q, first_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic             down_q, down_d;

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        rep_cnt_d = rep_cnt_q;
        first_d   = first_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d  = PRESS_CHK;
                    db_cnt_d = '0;
                end
            end
            PRESS_CHK: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = PRESSED;
                    press_d   = 1'b1;
                    rep_cnt_d = '0;
                    first_d   = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d  = RELEASE_CHK;
                    db_cnt_d = '0;
                end else if (REPEAT_EN != 0) begin
                    if ((first_q && rep_cnt_q == RD_LAST) || (!first_q && rep_cnt_q == RP_LAST)) begin
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                        first_d   = 1'b0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
            end
            RELEASE_CHK: begin
                // A bounce back to 1 resumes PRESSED with the repeat count left as it was.
                if (s) begin
                    state_d = PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == RELEASE_CHK);
        down_d  = press_d | repeat_d;
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q   <= RELEASED;
            db_cnt_q  <= '0;
            rep_cnt_q <= '0;
            first_q   <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            down_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            first_q   <= first_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            down_q    <= down_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;
    assign btn_down    = down_q;

endmodule
